fu_avail_ctrl: RTL
==================

FU_AVAIL_CTRL -- requirements
Module: fu_avail_ctrl

Interface
REQ-001 Parameter DIV_LAT, default 20, cycles a divide occupies the MUL unit.
REQ-002 Parameter VEC_OCC, default 2, cycles a vector op occupies its VEC unit.
REQ-003 Parameter MEM_CREDITS, default 16, load/store queue slots available to issue.
REQ-004 Parameter MAX_BR, default 8, maximum unresolved branches in flight.
REQ-005 clk  input  1  clock; all state updates on posedge clk.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 flush_i  input  1  pipeline flush; synchronous.
REQ-008 issue_valid_i  input  8  per-slot issue strobes from the issue queue.
REQ-009 issue_func_i  input  8x3  per-slot func type: 0 INT, 1 MUL, 2 VEC, 3 MEM, 4-7 BRANCH.
REQ-010 issue_long_i  input  8  per-slot divide flag; meaningful only for func 1.
REQ-011 int_stall_i  input  1  integer pipe backpressure.
REQ-012 mem_credit_ret_i  input  2  count (0-2) of LSQ slots returned this cycle.
REQ-013 branch_resolve_i  input  1  one branch resolved this cycle.
REQ-014 fu_int_free_o  output  2  INT units available this cycle.
REQ-015 fu_mul_free_o  output  1  MUL unit available this cycle.
REQ-016 fu_vec_free_o  output  2  free VEC units this cycle (0-2).
REQ-017 fu_mem_free_o  output  2  MEM issue slots available this cycle.
REQ-018 fu_branch_free_o  output  1  branch unit available this cycle.
REQ-019 err_oversub_o  output  1  sticky: issues exceeded advertised availability.

Function
REQ-020 Per-class issue counts SHALL be computed combinationally from slots with issue_valid_i set.
REQ-021 fu_int_free_o SHALL be 0 when int_stall_i=1, else 2; combinational, no state.
REQ-022 The MUL unit SHALL be pipelined for multiplies: a multiply issue does not clear fu_mul_free_o.
REQ-023 A divide issued in cycle t SHALL drive fu_mul_free_o=0 in cycles t+1..t+DIV_LAT, and 1 from t+DIV_LAT+1.
REQ-024 A VEC issue SHALL take the lowest-index free VEC unit, which is unavailable in cycles t+1..t+VEC_OCC-1.
REQ-025 fu_vec_free_o SHALL equal the number of VEC units with a zero busy counter.
REQ-026 The credit counter SHALL update as credits - mem_issues + mem_credit_ret_i, saturating at MEM_CREDITS.
REQ-027 fu_mem_free_o SHALL equal min(2, credits), taken from the registered counter; returns take effect next cycle.
REQ-028 The pending-branch counter SHALL increment on a branch issue and decrement on branch_resolve_i; both in one cycle leave it unchanged.
REQ-029 fu_branch_free_o SHALL be 1 iff pending < MAX_BR.
REQ-030 Oversubscription SHALL set err_oversub_o until reset, leaving the offending counter at its clamped bound. It covers: issue count above any advertised free value, credit underflow, or a resolve while pending=0.
REQ-031 On flush_i SHALL clear the divide counter, VEC busy counters and pending branches. Credits are kept; the LSQ returns them. flush_i has priority over same-cycle issues.
REQ-032 Every *_free_o output SHALL be a function of registered state plus int_stall_i only.

Reset
REQ-033 On rst_n low: divide/VEC counters 0, pending 0, credits MEM_CREDITS, err_oversub_o 0.
REQ-034 Reset-release outputs: fu_int_free_o=2 (stall low), fu_mul_free_o=1, fu_vec_free_o=2, fu_mem_free_o=2, fu_branch_free_o=1.
REQ-035 Reset asserted mid-divide SHALL abort it; fu_mul_free_o=1 on the first cycle after release.

Structure
REQ-036 Func-type encodings (FT_INT..FT_BR) and default parameter values SHALL live in the shared iq_pkg, also used by the issue queue.
REQ-037 The MUL and VEC occupancy counters SHALL be instances of one sub-module, fu_busy_counter: load value, clear, busy output.

Verification
REQ-038 Divide at t=10, DIV_LAT=20 -> fu_mul_free_o low cycles 11-30, high at 31; a multiply at t=10 instead keeps it high.
REQ-039 Two VEC issues at t=5, VEC_OCC=2 -> fu_vec_free_o=0 at t=6, 2 at t=7; one issue -> 1 at t=6.
REQ-040 Sixteen MEM issues (2/cycle), no returns -> fu_mem_free_o=0 after 8 cycles; return 1 -> next cycle 1.
REQ-041 Eight branch issues -> fu_branch_free_o=0; issue and resolve together -> stays 0; resolve only -> 1.
REQ-042 Divide in flight plus flush_i at t+5 -> fu_mul_free_o=1 at t+6, credits unchanged.
REQ-043 Two MUL-class issues in one cycle while fu_mul_free_o=0 -> err_oversub_o=1 next cycle and held until rst_n.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared issue-queue definitions: func-type encodings and default FU resource parameters.
// Used by the issue queue and by the functional-unit availability controller.
package iq_pkg;

    localparam int ISSUE_W   = 8;
    localparam int VEC_UNITS = 2;

    typedef logic [2:0] func_t;

    // Any encoding with bit 2 set is a branch; FT_BR is the canonical one.
    localparam func_t FT_INT = 3'd0;
    localparam func_t FT_MUL = 3'd1;
    localparam func_t FT_VEC = 3'd2;
    localparam func_t FT_MEM = 3'd3;
    localparam func_t FT_BR  = 3'd4;

    localparam int DIV_LAT_DEF     = 20;
    localparam int VEC_OCC_DEF     = 2;
    localparam int MEM_CREDITS_DEF = 16;
    localparam int MAX_BR_DEF      = 8;

    function automatic logic is_branch(input func_t f);
        return f[2];
    endfunction

endpackage

// File: rtl/fu_busy_counter.sv
// Occupancy down-counter for a non-pipelined unit: load on issue, count to zero, busy while non-zero.
// Clear wins over load so a flush always leaves the unit idle.
module fu_busy_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_busy
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_busy = (r_count != '0);

endmodule

// File: rtl/fu_avail_ctrl.sv
// Functional-unit availability tracker: advertises free INT/MUL/VEC/MEM/branch capacity to the
// issue queue from registered state, and flags (sticky) any issue beyond what was advertised.
module fu_avail_ctrl
    import iq_pkg::*;
#(
    parameter int DIV_LAT     = DIV_LAT_DEF,
    parameter int VEC_OCC     = VEC_OCC_DEF,
    parameter int MEM_CREDITS = MEM_CREDITS_DEF,
    parameter int MAX_BR      = MAX_BR_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic [ISSUE_W-1:0]    issue_valid_i,
    input  func_t [ISSUE_W-1:0]   issue_func_i,
    input  logic [ISSUE_W-1:0]    issue_long_i,
    input  logic                  int_stall_i,
    input  logic [1:0]            mem_credit_ret_i,
    input  logic                  branch_resolve_i,
    output logic [1:0]            fu_int_free_o,
    output logic                  fu_mul_free_o,
    output logic [1:0]            fu_vec_free_o,
    output logic [1:0]            fu_mem_free_o,
    output logic                  fu_branch_free_o,
    output logic                  err_oversub_o
);

    localparam int CNT_W  = $clog2(ISSUE_W + 1);
    localparam int DIV_W  = $clog2(DIV_LAT + 1);
    localparam int VEC_W  = $clog2(VEC_OCC + 1);
    localparam int CR_RAW = $clog2(MEM_CREDITS + 3);
    localparam int CR_W   = (CR_RAW > CNT_W) ? CR_RAW : CNT_W;
    localparam int BR_W   = $clog2(MAX_BR + ISSUE_W + 1);

    logic [CNT_W-1:0]     w_int_cnt, w_mul_cnt, w_vec_cnt, w_mem_cnt, w_br_cnt;
    logic                 w_div_issue;
    logic                 w_mul_busy;
    logic [VEC_UNITS-1:0] w_vec_busy, w_vec_load;
    logic [CNT_W-1:0]     w_vec_granted;
    logic [1:0]           w_vec_free_cnt;
    logic [CR_W-1:0]      w_mem_eff, w_cr_sum, w_cr_diff, w_cr_next;
    logic                 w_cr_under;
    logic [BR_W-1:0]      w_br_sum, w_br_next;
    logic                 w_br_under;
    logic                 w_oversub;

    logic [CR_W-1:0]      r_credits;
    logic [BR_W-1:0]      r_pending;
    logic                 r_err;

    always_comb begin
        w_int_cnt   = '0;
        w_mul_cnt   = '0;
        w_vec_cnt   = '0;
        w_mem_cnt   = '0;
        w_br_cnt    = '0;
        w_div_issue = 1'b0;
        for (int s = 0; s < ISSUE_W; s++) begin
            if (issue_valid_i[s]) begin
                if (is_branch(issue_func_i[s])) begin
                    w_br_cnt = w_br_cnt + 1'b1;
                end else begin
                    case (issue_func_i[s])
                        FT_INT: w_int_cnt = w_int_cnt + 1'b1;
                        FT_MUL: begin
                            w_mul_cnt = w_mul_cnt + 1'b1;
                            if (issue_long_i[s]) w_div_issue = 1'b1;
                        end
                        FT_VEC: w_vec_cnt = w_vec_cnt + 1'b1;
                        FT_MEM: w_mem_cnt = w_mem_cnt + 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Multiplies are pipelined; only a divide occupies the MUL unit.
    fu_busy_counter #(.W(DIV_W)) u_div_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (flush_i),
        .i_load     (w_div_issue),
        .i_load_val (DIV_W'(DIV_LAT)),
        .o_busy     (w_mul_busy)
    );

    // Hand VEC issues to the lowest-index idle units first.
    always_comb begin
        w_vec_load    = '0;
        w_vec_granted = '0;
        for (int u = 0; u < VEC_UNITS; u++) begin
            if (!w_vec_busy[u] && (w_vec_granted < w_vec_cnt)) begin
                w_vec_load[u] = 1'b1;
                w_vec_granted = w_vec_granted + 1'b1;
            end
        end
    end

    for (genvar u = 0; u < VEC_UNITS; u++) begin : g_vec
        fu_busy_counter #(.W(VEC_W)) u_vec_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_clear    (flush_i),
            .i_load     (w_vec_load[u]),
            .i_load_val (VEC_W'(VEC_OCC - 1)),
            .o_busy     (w_vec_busy[u])
        );
    end

    always_comb begin
        w_vec_free_cnt = '0;
        for (int u = 0; u < VEC_UNITS; u++) begin
            if (!w_vec_busy[u]) w_vec_free_cnt = w_vec_free_cnt + 1'b1;
        end
    end

    // Flushed MEM issues never reach the LSQ, so they consume no credit.
    always_comb begin
        w_mem_eff  = flush_i ? '0 : CR_W'(w_mem_cnt);
        w_cr_sum   = r_credits + CR_W'(mem_credit_ret_i);
        w_cr_under = (w_cr_sum < w_mem_eff);
        w_cr_diff  = w_cr_sum - w_mem_eff;
        if (w_cr_under) begin
            w_cr_next = '0;
        end else if (w_cr_diff > CR_W'(MEM_CREDITS)) begin
            w_cr_next = CR_W'(MEM_CREDITS);
        end else begin
            w_cr_next = w_cr_diff;
        end
    end

    always_comb begin
        w_br_sum   = r_pending + BR_W'(w_br_cnt);
        w_br_under = branch_resolve_i && (w_br_sum == '0);
        w_br_next  = w_br_sum;
        if (branch_resolve_i && (w_br_sum != '0)) w_br_next = w_br_sum - 1'b1;
        if (w_br_next > BR_W'(MAX_BR)) w_br_next = BR_W'(MAX_BR);
    end

    assign w_oversub = !flush_i && (
        (w_int_cnt > CNT_W'(fu_int_free_o))    ||
        (w_mul_cnt > CNT_W'(fu_mul_free_o))    ||
        (w_vec_cnt > CNT_W'(fu_vec_free_o))    ||
        (w_mem_cnt > CNT_W'(fu_mem_free_o))    ||
        (w_br_cnt  > CNT_W'(fu_branch_free_o)) ||
        w_cr_under || w_br_under);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= CR_W'(MEM_CREDITS);
            r_pending <= '0;
            r_err     <= 1'b0;
        end else begin
            r_credits <= w_cr_next;
            r_pending <= flush_i ? '0 : w_br_next;
            if (w_oversub) r_err <= 1'b1;
        end
    end

    assign fu_int_free_o    = int_stall_i ? 2'd0 : 2'd2;
    assign fu_mul_free_o    = ~w_mul_busy;
    assign fu_vec_free_o    = w_vec_free_cnt;
    assign fu_mem_free_o    = (r_credits >= CR_W'(2)) ? 2'd2 : r_credits[1:0];
    assign fu_branch_free_o = (r_pending < BR_W'(MAX_BR));
    assign err_oversub_o    = r_err;

endmodule
